// File: rtl/snow_pkg.sv
// Shared types and default sizing for the snowflake game-level controller.
package snow_pkg;

  localparam int unsigned N_SNOW_DEF  = 15;
  localparam int unsigned SCORE_W_DEF = 4;
  localparam int unsigned PTR_W_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first set bit of req searching upward from ptr,
// wrapping N-1 -> 0. Purely combinational, reusable by slot-based managers.
module rr_pick #(
  parameter int unsigned N     = 15,
  parameter int unsigned PTR_W = 4
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic             valid,
  output logic [PTR_W-1:0] idx
);

  localparam int unsigned SW = PTR_W + 1;

  logic [N-1:0]     rot;
  logic [PTR_W-1:0] off;
  logic [SW-1:0]    sum;

  // Rotate req so ptr lands at bit 0, take the lowest set bit, then undo the rotation.
  always_comb begin
    rot   = N'({req, req} >> ptr);
    valid = 1'b0;
    off   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (rot[i]) begin
        valid = 1'b1;
        off   = PTR_W'(i);
      end
    end
    sum = SW'(ptr) + SW'(off);
    if (sum >= SW'(N)) begin
      sum = sum - SW'(N);
    end
    idx = sum[PTR_W-1:0];
  end

endmodule

// File: rtl/snowf_score_ctrl.sv
// Game-level controller: arms the snowflake slots, captures collision hits,
// credits them to the score one per cycle in round-robin order and flags
// level clear once every flake is collected.
module snowf_score_ctrl
  import snow_pkg::*;
#(
  parameter int unsigned N_SNOW  = N_SNOW_DEF,
  parameter int unsigned SCORE_W = SCORE_W_DEF,
  parameter int unsigned PTR_W   = PTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N_SNOW-1:0]  snowf_hit,
  output logic [N_SNOW-1:0]  snowf_active,
  output logic [SCORE_W-1:0] score,
  output logic               level_clear,
  output logic               playing
);

  localparam logic [N_SNOW-1:0]  ALL_SLOTS = '1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_t             state_q, state_d;
  logic [N_SNOW-1:0]  pending_q, pending_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [N_SNOW-1:0]  active_d;
  logic [SCORE_W-1:0] score_d;
  logic               level_clear_d;
  logic               playing_d;

  logic               grant_valid;
  logic [PTR_W-1:0]   grant_idx;
  logic [N_SNOW-1:0]  grant_mask;
  logic [N_SNOW-1:0]  cap;

  // Grant selection over hits already captured (never this cycle's captures).
  rr_pick #(
    .N     (N_SNOW),
    .PTR_W (PTR_W)
  ) u_pick (
    .req   (pending_q),
    .ptr   (ptr_q),
    .valid (grant_valid),
    .idx   (grant_idx)
  );

  // Hits only count on slots still visible, so a held hit captures once.
  always_comb begin
    cap        = snowf_hit & snowf_active;
    grant_mask = grant_valid ? (N_SNOW'(1) << grant_idx) : '0;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    active_d      = snowf_active;
    pending_d     = pending_q;
    score_d       = score;
    ptr_d         = ptr_q;
    level_clear_d = 1'b0;

    if (start) begin
      // Level (re)start from any state drops uncredited hits.
      state_d   = PLAY;
      active_d  = ALL_SLOTS;
      pending_d = '0;
      score_d   = '0;
      ptr_d     = '0;
    end else begin
      case (state_q)
        PLAY, DRAIN: begin
          active_d  = snowf_active & ~cap;
          pending_d = (pending_q & ~grant_mask) | cap;
          if (grant_valid) begin
            if (score != SCORE_MAX) begin
              score_d = score + SCORE_W'(1);
            end
            ptr_d = (grant_idx == PTR_W'(N_SNOW - 1)) ? '0 : grant_idx + PTR_W'(1);
          end
          if (active_d == '0) begin
            if (pending_d == '0) begin
              state_d       = DONE;
              level_clear_d = 1'b1;
            end else begin
              state_d = DRAIN;
            end
          end
        end
        default: begin
        end
      endcase
    end

    playing_d = (state_d == PLAY) || (state_d == DRAIN);
  end

  // State, bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      ptr_q        <= '0;
      snowf_active <= '0;
      score        <= '0;
      level_clear  <= 1'b0;
      playing      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      ptr_q        <= ptr_d;
      snowf_active <= active_d;
      score        <= score_d;
      level_clear  <= level_clear_d;
      playing      <= playing_d;
    end
  end

endmodule

// File: tb/tb_snowf_score_ctrl.sv
// Directed bench for snowf_score_ctrl: a cycle table for the basic level
// flow plus hand-written sequences for burst drain, round-robin order,
// restart and mid-level reset.
module tb_snowf_score_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [14:0] snowf_hit;
  logic [14:0] snowf_active;
  logic [3:0]  score;
  logic        level_clear;
  logic        playing;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        start;
    logic [14:0] hit;
    logic [14:0] act;
    logic [3:0]  score;
    logic        clr;
    logic        play;
  } vec_t;

  vec_t tbl [9];

  snowf_score_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .snowf_hit    (snowf_hit),
    .snowf_active (snowf_active),
    .score        (score),
    .level_clear  (level_clear),
    .playing      (playing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string name, input logic [14:0] act, input logic [3:0] sc,
                          input logic clr, input logic play);
    chk({name, ".active"}, 32'(snowf_active), 32'(act));
    chk({name, ".score"}, 32'(score), 32'(sc));
    chk({name, ".clear"}, 32'(level_clear), 32'(clr));
    chk({name, ".playing"}, 32'(playing), 32'(play));
  endtask

  task automatic step(input logic s, input logic [14:0] h);
    start     = s;
    snowf_hit = h;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_pend;
    logic [14:0] rr_pend [4];
    logic [3:0]  rr_ptr  [4];

    // start, hit, active, score, clear, playing
    tbl[0] = '{1'b1, 15'h0000, 15'h7FFF, 4'd0, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 15'h0008, 15'h7FF7, 4'd0, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 15'h0008, 15'h7FF7, 4'd1, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 15'h0008, 15'h7FF7, 4'd1, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 15'h0011, 15'h7FE6, 4'd1, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 15'h0000, 15'h7FE6, 4'd2, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 15'h0000, 15'h7FE6, 4'd3, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 15'h0000, 15'h7FE6, 4'd3, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 15'h7FFF, 15'h0000, 4'd3, 1'b0, 1'b1};

    rr_pend = '{15'h1084, 15'h1004, 15'h0004, 15'h0000};
    rr_ptr  = '{4'd5, 4'd8, 4'd13, 4'd3};

    rst_n     = 1'b0;
    start     = 1'b0;
    snowf_hit = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_outs("reset", 15'h0000, 4'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Level flow: arm, held hit on slot 3, two more hits, then the rest at once.
    for (int i = 0; i < 9; i++) begin
      if (i == 4) begin
        for (int c = 0; c < 17; c++) begin
          step(1'b0, 15'h0008);
          chk_outs($sformatf("hold%0d", c), 15'h7FF7, 4'd1, 1'b0, 1'b1);
        end
      end
      step(tbl[i].start, tbl[i].hit);
      chk_outs($sformatf("vec%0d", i), tbl[i].act, tbl[i].score, tbl[i].clr, tbl[i].play);
    end
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, 15'h0000);
      chk_outs($sformatf("drainA%0d", k), 15'h0000, 4'(3 + k), k == 12, k != 12);
    end
    step(1'b0, 15'h0000);
    chk_outs("doneA", 15'h0000, 4'd15, 1'b0, 1'b0);

    // Every slot hit in a single cycle: drains in slot order 0..14.
    step(1'b1, 15'h0000);
    chk_outs("armB", 15'h7FFF, 4'd0, 1'b0, 1'b1);
    step(1'b0, 15'h7FFF);
    chk_outs("burstB", 15'h0000, 4'd0, 1'b0, 1'b1);
    chk("burstB.state", 32'(dut.state_q), 32'(2));
    chk("burstB.pending", 32'(dut.pending_q), 32'h7FFF);
    for (int k = 1; k <= 15; k++) begin
      step(1'b0, 15'h0000);
      exp_pend = 32'h7FFF & ~((32'd1 << k) - 32'd1);
      chk_outs($sformatf("drainB%0d", k), 15'h0000, 4'(k), k == 15, k != 15);
      chk($sformatf("drainB%0d.pending", k), 32'(dut.pending_q), exp_pend);
    end

    // Round robin from ptr=5 over pending {2,7,12}.
    step(1'b1, 15'h0000);
    step(1'b0, 15'h0010);
    chk_outs("rrC.hit4", 15'h7FEF, 4'd0, 1'b0, 1'b1);
    step(1'b0, 15'h0000);
    chk("rrC.ptr5", 32'(dut.ptr_q), 32'd5);
    chk("rrC.score1", 32'(score), 32'd1);
    step(1'b0, 15'h1084);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step(1'b0, 15'h0000);
      chk($sformatf("rrC%0d.pending", k), 32'(dut.pending_q), 32'(rr_pend[k]));
      chk($sformatf("rrC%0d.ptr", k), 32'(dut.ptr_q), 32'(rr_ptr[k]));
      chk_outs($sformatf("rrC%0d", k), 15'h6F6B, 4'(1 + k), 1'b0, 1'b1);
    end

    // Restart mid-level after 4 flakes: score clears, no clear pulse.
    step(1'b1, 15'h0000);
    chk_outs("restart", 15'h7FFF, 4'd0, 1'b0, 1'b1);
    step(1'b0, 15'h0200);
    chk_outs("restart.hit", 15'h7DFF, 4'd0, 1'b0, 1'b1);
    step(1'b0, 15'h0000);
    chk_outs("restart.credit", 15'h7DFF, 4'd1, 1'b0, 1'b1);

    // Reach DRAIN with pending 0x0070, then reset asynchronously.
    step(1'b1, 15'h0000);
    step(1'b0, 15'h7F8F);
    chk_outs("drainD.cap", 15'h0070, 4'd0, 1'b0, 1'b1);
    repeat (12) step(1'b0, 15'h0000);
    chk_outs("drainD.credit", 15'h0070, 4'd12, 1'b0, 1'b1);
    step(1'b0, 15'h0070);
    chk("drainD.state", 32'(dut.state_q), 32'(2));
    chk("drainD.pending", 32'(dut.pending_q), 32'h0070);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs("asyncrst", 15'h0000, 4'd0, 1'b0, 1'b0);
    chk("asyncrst.pending", 32'(dut.pending_q), 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) step(1'b0, 15'h0000);
    chk_outs("postrst", 15'h0000, 4'd0, 1'b0, 1'b0);
    chk("postrst.state", 32'(dut.state_q), 32'(0));
    step(1'b1, 15'h0000);
    chk_outs("postrst.start", 15'h7FFF, 4'd0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/snowf_score_ctrl.md
Name: snowf_score_ctrl

Overview:
- Game-level controller for the 15 snowflake slots.
- Arms all slots at level start and captures collision hits, including hits that arrive in the same cycle.
- Round-robin scheduler credits captured hits to the score one per cycle.
- Flags level clear when every flake is collected. Sits between the sprite-collision logic and the score display / VGA overlay.

Parameters:
- N_SNOW, 15, number of snowflake slots (2..32).
- SCORE_W, 4, score width; must satisfy 2^SCORE_W-1 >= N_SNOW.
- PTR_W, 4, slot-pointer width; must satisfy 2^PTR_W >= N_SNOW.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin/restart level; single-cycle pulse or level, sampled each cycle.
- snowf_hit  in  N_SNOW  raw collision per slot; may stay high for many cycles.
- snowf_active  out  N_SNOW  slot visible/collectable (drives renderer).
- score  out  SCORE_W  flakes credited this level.
- level_clear  out  1  one-cycle pulse when the level completes.
- playing  out  1  high while in PLAY or DRAIN.

Behaviour:
- Reset (async assert, sync release): state=IDLE, snowf_active=0, pending=0, score=0, ptr=0, level_clear=0, playing=0.
- States: IDLE, PLAY, DRAIN, DONE.
- IDLE: outputs held. start=1 -> PLAY next edge, with snowf_active=all ones, pending=0, score=0, ptr=0.
- PLAY, capture:
  - cap = snowf_hit & snowf_active.
  - Next edge: snowf_active &= ~cap and pending |= cap.
  - Each flake is captured exactly once, however long its hit is held. Hits on inactive slots are ignored.
- PLAY/DRAIN, scheduler:
  - If pending != 0, grant g = first set bit of pending searching upward from ptr, wrapping N_SNOW-1 -> 0.
  - Next edge: clear pending[g], score+1, ptr = (g==N_SNOW-1) ? 0 : g+1.
  - At most one grant per cycle.
  - A bit newly captured in a cycle is not grantable until the following cycle.
- Score saturates at 2^SCORE_W-1 and never wraps.
- Latency: hit on an idle scheduler -> snowf_active bit clears at edge+1, score increments at edge+2.
- Worst case: all N_SNOW hits in one cycle -> score reaches N_SNOW at edge+1+N_SNOW.
- Transitions:
  - PLAY -> DRAIN when next snowf_active == 0 but pending != 0.
  - PLAY -> DONE directly when both become 0 on the same edge.
  - DRAIN -> DONE on the edge that clears the last pending bit.
  - level_clear=1 for exactly the first cycle in DONE.
- DONE: score held, snowf_active=0. start -> PLAY (re-arm as from IDLE).
- start during PLAY/DRAIN: restarts immediately (re-arm, pending=0, score=0). Uncredited hits are discarded. No level_clear pulse.
- Reset mid-level: everything returns to reset values asynchronously; no partial credit survives.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package snow_pkg: state enum (IDLE/PLAY/DRAIN/DONE), N_SNOW_DEF=15, SCORE_W_DEF=4, PTR_W_DEF=4.
- Sub-module rr_pick (params N, PTR_W):
  - Inputs: req[N-1:0], ptr.
  - Outputs: valid, idx. Purely combinational rotate-priority encoder.
  - Reusable by other slot-based sprite managers.
- Controller holds the FSM, capture/pending registers, score counter and pointer.

Test Plan:
- Reset then start pulse -> next cycle snowf_active=0x7FFF, score=0, playing=1, level_clear=0.
- snowf_hit[3] held high 20 cycles -> snowf_active[3]=0 after 1 cycle; score=1 after 2 cycles and stays 1.
- Simultaneous snowf_hit=0x7FFF for one cycle:
  - snowf_active=0 next cycle and state=DRAIN.
  - score increments 1..15 on consecutive cycles, grant order slot 0..14.
  - level_clear pulses once when score=15.
- Round-robin order with ptr=5, pending={2,7,12}: grants in order 7, 12, 2; ptr ends at 3.
- Restart mid-level: 4 flakes collected, then start -> score=0, snowf_active=0x7FFF, no level_clear; a hit then counts from 1.
- rst_n asserted during DRAIN with pending=0x0070 -> all outputs 0 immediately (before next clock); after release, remains IDLE until start.
